// File: rtl/gfsk_mod_multirate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gfsk_mod_multirate : framed GFSK fmod generator, LE 1M/2M upsampling, symmetric FIR
// Build macro GFSK_MOD_SAT_EN selects saturating output plus sticky sat_flag. Rev 1.0
// ---------------------------------------------------------------------------
module gfsk_mod_multirate #(
    parameter int SAMPLE_PER_SYMBOL = 8,
    parameter int NUM_TAP           = 17,
    parameter int COEF_WIDTH        = 8,
    parameter int GUARD_LEN         = 8,
    parameter int OUT_SHIFT         = 0,
    parameter int FMOD_WIDTH        = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tap_we,
    input  logic [4:0]                   tap_index,
    input  logic signed [COEF_WIDTH-1:0] tap_value,
    input  logic                         start,
    input  logic                         mode_2m,
    input  logic                         phy_bit,
    input  logic                         bit_valid,
    input  logic                         bit_last,
    output logic                         bit_ready,
    output logic signed [FMOD_WIDTH-1:0] fmod,
    output logic                         fmod_valid,
    output logic                         fmod_last,
    output logic                         busy,
    output logic                         underrun_err
`ifdef GFSK_MOD_SAT_EN
    ,
    output logic                         sat_flag
`endif
);
    localparam int NCOEF = (NUM_TAP + 1) / 2;
    localparam int ACC_W = COEF_WIDTH + $clog2(NUM_TAP) + 1;
    localparam int EXT_W = (ACC_W > FMOD_WIDTH) ? ACC_W : FMOD_WIDTH;
    localparam logic [7:0] GUARD_END = 8'(GUARD_LEN - 1);
    localparam logic [7:0] FLUSH_END = 8'(NUM_TAP - 2);
    localparam logic [7:0] SPS1_M1   = 8'(SAMPLE_PER_SYMBOL - 1);
    localparam logic [7:0] SPS2_M1   = 8'(SAMPLE_PER_SYMBOL / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_FLUSH} state_t;

    state_t                       state;
    logic [7:0]                   cnt;
    logic [7:0]                   sps_m1;
    logic                         held_bit;
    logic                         held_last;
    logic signed [COEF_WIDTH-1:0] coef  [NCOEF];
    logic signed [COEF_WIDTH-1:0] cfull [NUM_TAP];
    logic [1:0]                   dline [NUM_TAP];
    logic                         dvalid;
    logic                         dlast;

    logic                         pre_end;
    logic                         data_end;
    logic                         flush_end;
    logic                         start_ok;
    logic [1:0]                   samp;
    logic signed [ACC_W-1:0]      acc;
    logic signed [EXT_W-1:0]      shifted;
    logic signed [FMOD_WIDTH-1:0] fmod_next;
    logic                         ovf;

    assign pre_end   = (state == S_PRE)   && (cnt == GUARD_END);
    assign data_end  = (state == S_DATA)  && (cnt == sps_m1);
    assign flush_end = (state == S_FLUSH) && (cnt == FLUSH_END);
    assign bit_ready = pre_end || (data_end && !held_last);
    assign busy      = (state != S_IDLE) || dvalid || fmod_valid;
    assign start_ok  = start && !busy;
    // Delay-line sample code: bit0 = nonzero, bit1 = negative.
    assign samp      = (state == S_DATA) ? (held_bit ? 2'b01 : 2'b11) : 2'b00;

    for (genvar k = 0; k < NUM_TAP; k++) begin : g_mirror
        assign cfull[k] = coef[(k < NCOEF) ? k : (NUM_TAP - 1 - k)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            sps_m1       <= '0;
            held_bit     <= 1'b0;
            held_last    <= 1'b0;
            underrun_err <= 1'b0;
            for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
        end else begin
            if (tap_we && !busy) begin
                for (int i = 0; i < NCOEF; i++)
                    if (tap_index == 5'(i)) coef[i] <= tap_value;
            end
            case (state)
                S_IDLE: if (start_ok) begin
                    state        <= S_PRE;
                    cnt          <= '0;
                    sps_m1       <= mode_2m ? SPS2_M1 : SPS1_M1;
                    underrun_err <= 1'b0;
                end
                S_PRE, S_DATA: begin
                    if (pre_end || data_end) begin
                        cnt <= '0;
                        if (data_end && held_last) begin
                            state <= S_FLUSH;
                        end else if (bit_valid) begin
                            state     <= S_DATA;
                            held_bit  <= phy_bit;
                            held_last <= bit_last;
                        end else begin
                            state        <= S_FLUSH;
                            underrun_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_FLUSH: begin
                    cnt <= flush_end ? 8'd0 : cnt + 8'd1;
                    if (flush_end) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAP; k++) begin
            if (dline[k][0])
                acc = dline[k][1] ? acc - ACC_W'(cfull[k]) : acc + ACC_W'(cfull[k]);
        end
    end

    always_comb begin
        shifted   = $signed(EXT_W'(acc)) >>> OUT_SHIFT;
        ovf       = 1'b0;
        fmod_next = FMOD_WIDTH'(shifted);
`ifdef GFSK_MOD_SAT_EN
        ovf = (shifted[EXT_W-1:FMOD_WIDTH-1] != {(EXT_W-FMOD_WIDTH+1){shifted[EXT_W-1]}});
        if (ovf)
            fmod_next = shifted[EXT_W-1] ? {1'b1, {(FMOD_WIDTH-1){1'b0}}}
                                         : {1'b0, {(FMOD_WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAP; k++) dline[k] <= '0;
            dvalid     <= 1'b0;
            dlast      <= 1'b0;
            fmod       <= '0;
            fmod_valid <= 1'b0;
            fmod_last  <= 1'b0;
`ifdef GFSK_MOD_SAT_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                for (int k = 0; k < NUM_TAP; k++) dline[k] <= '0;
            end else if (state != S_IDLE) begin
                dline[0] <= samp;
                for (int k = 1; k < NUM_TAP; k++) dline[k] <= dline[k-1];
            end
            dvalid     <= (state != S_IDLE);
            dlast      <= flush_end;
            fmod_valid <= dvalid;
            fmod_last  <= dlast;
            fmod       <= dvalid ? fmod_next : '0;
`ifdef GFSK_MOD_SAT_EN
            if (start_ok)          sat_flag <= 1'b0;
            else if (dvalid && ovf) sat_flag <= 1'b1;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gfsk_mod_multirate.sv
`default_nettype none
// Bench for gfsk_mod_multirate: spec-level convolution model plus literal pins, default and 6-bit builds.
module tb_gfsk_mod_multirate;
    localparam int SPS = 8, NT = 17, CW = 8, GL = 8, FW = 12, FW6 = 6, OS = 0;

    logic clk = 1'b0;
    logic rst, tap_we, start, mode_2m, phy_bit, bit_valid, bit_last;
    logic [4:0] tap_index;
    logic signed [CW-1:0] tap_value;
    logic bit_ready, fmod_valid, fmod_last, busy, underrun_err;
    logic signed [FW-1:0] fmod;
    logic bit_ready6, fmod_valid6, fmod_last6, busy6, underrun6;
    logic signed [FW6-1:0] fmod6;
`ifdef GFSK_MOD_SAT_EN
    logic sat_flag, sat_flag6;
`endif

    gfsk_mod_multirate #(.SAMPLE_PER_SYMBOL(SPS), .NUM_TAP(NT), .COEF_WIDTH(CW), .GUARD_LEN(GL),
                         .OUT_SHIFT(OS), .FMOD_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .tap_we(tap_we), .tap_index(tap_index), .tap_value(tap_value),
        .start(start), .mode_2m(mode_2m), .phy_bit(phy_bit), .bit_valid(bit_valid),
        .bit_last(bit_last), .bit_ready(bit_ready), .fmod(fmod), .fmod_valid(fmod_valid),
        .fmod_last(fmod_last), .busy(busy), .underrun_err(underrun_err)
`ifdef GFSK_MOD_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    gfsk_mod_multirate #(.SAMPLE_PER_SYMBOL(SPS), .NUM_TAP(NT), .COEF_WIDTH(CW), .GUARD_LEN(GL),
                         .OUT_SHIFT(OS), .FMOD_WIDTH(FW6)) dut6 (
        .clk(clk), .rst(rst), .tap_we(tap_we), .tap_index(tap_index), .tap_value(tap_value),
        .start(start), .mode_2m(mode_2m), .phy_bit(phy_bit), .bit_valid(bit_valid),
        .bit_last(bit_last), .bit_ready(bit_ready6), .fmod(fmod6), .fmod_valid(fmod_valid6),
        .fmod_last(fmod_last6), .busy(busy6), .underrun_err(underrun6)
`ifdef GFSK_MOD_SAT_EN
        , .sat_flag(sat_flag6)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int ctap [9];
    int exp_y[$], exp_y6[$], cap_y[$], cap_y6[$];
    int n_out = 0;
    bit in_frame = 1'b0;
    bit fb [16];

    function automatic void chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic int reduce(input int v, input int w);
        int sh = v >>> OS;
        int hi = (1 << (w - 1)) - 1;
        int r;
`ifdef GFSK_MOD_SAT_EN
        if (sh > hi) return hi;
        if (sh < -hi - 1) return -hi - 1;
        return sh;
`else
        r = sh & ((1 << w) - 1);
        if (r > hi) r -= (1 << w);
        return r;
`endif
    endfunction

    // Frame model: build the input-sample sequence from the framing rules, then convolve.
    task automatic build_model(input bit m2, input int nb);
        int s[$];
        int sps = m2 ? SPS / 2 : SPS;
        int acc, kk;
        repeat (GL) s.push_back(0);
        for (int i = 0; i < nb; i++) repeat (sps) s.push_back(fb[i] ? 1 : -1);
        repeat (NT - 1) s.push_back(0);
        exp_y.delete(); exp_y6.delete(); cap_y.delete(); cap_y6.delete();
        for (int n = 0; n < s.size(); n++) begin
            acc = 0;
            for (int k = 0; k < NT; k++) begin
                kk = (k < 9) ? k : NT - 1 - k;
                if (n - k >= 0) acc += ctap[kk] * s[n-k];
            end
            exp_y.push_back(reduce(acc, FW));
            exp_y6.push_back(reduce(acc, FW6));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && fmod_valid) begin
            if (n_out < int'(exp_y.size())) begin
                chk("fmod", int'(fmod), exp_y[n_out]);
                chk("fmod6", int'(fmod6), exp_y6[n_out]);
                chk("fmod_last", int'(fmod_last), int'(n_out == int'(exp_y.size()) - 1));
                chk("fmod_last6", int'(fmod_last6), int'(n_out == int'(exp_y.size()) - 1));
                chk("fmod_valid6", int'(fmod_valid6), 1);
            end else begin
                chk("extra_sample", n_out, int'(exp_y.size()) - 1);
            end
            cap_y.push_back(int'(fmod));
            cap_y6.push_back(int'(fmod6));
            n_out++;
        end else if (!rst && in_frame && n_out > 0 && n_out < int'(exp_y.size())) begin
            chk("fmod_valid_gap", int'(fmod_valid), 1);
        end
    end

    task automatic write_tap(input int idx, input int val);
        @(negedge clk);
        tap_we = 1'b1; tap_index = 5'(idx); tap_value = CW'(val);
        @(negedge clk);
        tap_we = 1'b0;
    endtask

    task automatic set_all_taps(input int v);
        for (int i = 0; i < 9; i++) begin
            write_tap(i, v);
            ctap[i] = v;
        end
    endtask

    task automatic run_frame(input bit m2, input int nb, input bit lastflag,
                             input int abort_at, input bit poke);
        int idx = 0, lat = 0;
        bit done = 1'b0, aborted = 1'b0;
        build_model(m2, nb);
        n_out = 0;
        @(negedge clk);
        start = 1'b1; mode_2m = m2;
        @(negedge clk);
        start = 1'b0;
        in_frame = 1'b1;
        fork
            begin
                while (!fmod_valid && lat < 20) begin
                    @(posedge clk); #1; lat++;
                end
                if (!aborted) chk("latency", lat, 2);
            end
            begin
                for (int c = 0; c < 600; c++) begin
                    @(negedge clk);
                    if (c == abort_at) begin
                        in_frame = 1'b0;
                        #2 rst = 1'b1;
                        #1;
                        chk("rst_fmod", int'(fmod), 0);
                        chk("rst_fmod_valid", int'(fmod_valid), 0);
                        chk("rst_fmod_last", int'(fmod_last), 0);
                        chk("rst_busy", int'(busy), 0);
                        chk("rst_bit_ready", int'(bit_ready), 0);
                        chk("rst_fmod6", int'(fmod6), 0);
                        @(posedge clk); #1;
                        rst = 1'b0;
                        aborted = 1'b1;
                        break;
                    end
                    if (!busy) begin
                        done = 1'b1;
                        break;
                    end
                    bit_valid = (idx < nb);
                    phy_bit   = (idx < nb) ? fb[idx] : 1'b0;
                    bit_last  = lastflag && (idx == nb - 1);
                    if (bit_valid && bit_ready) idx++;
                end
                bit_valid = 1'b0; bit_last = 1'b0;
                if (!done && !aborted) chk("frame_timeout", 0, 1);
            end
            begin
                if (poke) begin
                    repeat (12) @(negedge clk);
                    tap_we = 1'b1; tap_index = 5'd0; tap_value = 8'sd99;
                    @(negedge clk);
                    tap_index = 5'd8; tap_value = -8'sd50;
                    @(negedge clk);
                    tap_we = 1'b0; start = 1'b1; mode_2m = ~m2;
                    @(negedge clk);
                    start = 1'b0; mode_2m = m2;
                end
            end
        join
        in_frame = 1'b0;
        if (!aborted) begin
            chk("sample_count", n_out, int'(exp_y.size()));
            chk("underrun_err", int'(underrun_err), int'(!lastflag));
            chk("busy_end", int'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b1; tap_we = 1'b0; tap_index = '0; tap_value = '0; start = 1'b0;
        mode_2m = 1'b0; phy_bit = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
        for (int i = 0; i < 9; i++) ctap[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fmod", int'(fmod), 0);
        chk("reset_fmod_valid", int'(fmod_valid), 0);
        chk("reset_fmod_last", int'(fmod_last), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_bit_ready", int'(bit_ready), 0);
        chk("reset_underrun", int'(underrun_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // All taps 1, 1M, four ones.
        set_all_taps(1);
        for (int i = 0; i < 4; i++) fb[i] = 1'b1;
        run_frame(1'b0, 4, 1'b1, -1, 1'b0);
        if (cap_y.size() >= 31) begin
            chk("t1_guard_zero", cap_y[7], 0);
            chk("t1_ramp_start", cap_y[8], 1);
            chk("t1_plateau", cap_y[30], 17);
        end
        chk("t1_len", int'(cap_y.size()), 56);

        // 2M, alternating bits.
        fb[0] = 1; fb[1] = 0; fb[2] = 1; fb[3] = 0;
        run_frame(1'b1, 4, 1'b1, -1, 1'b0);
        if (cap_y.size() >= 16) begin
            chk("t2_after_4", cap_y[11], 4);
            chk("t2_cancel", cap_y[15], 0);
        end
        chk("t2_len", int'(cap_y.size()), 40);

        // Centre tap only; out-of-range indices must be ignored.
        set_all_taps(0);
        write_tap(8, 5); ctap[8] = 5;
        write_tap(9, 77);
        write_tap(31, -1);
        fb[0] = 0;
        run_frame(1'b0, 1, 1'b1, -1, 1'b0);
        if (cap_y.size() >= 25) begin
            chk("t3_before", cap_y[15], 0);
            chk("t3_first", cap_y[16], -5);
            chk("t3_last", cap_y[23], -5);
            chk("t3_after", cap_y[24], 0);
        end

        // Underrun after two bits.
        set_all_taps(1);
        fb[0] = 1; fb[1] = 0;
        run_frame(1'b0, 2, 1'b0, -1, 1'b0);
        chk("t4_len", int'(cap_y.size()), 40);

        // Tap writes and a stray start during a frame are dropped.
        fb[0] = 1; fb[1] = 1; fb[2] = 0; fb[3] = 1;
        run_frame(1'b0, 4, 1'b1, -1, 1'b1);

        // Large taps: 12-bit holds 68, 6-bit wraps or clips.
        set_all_taps(4);
        for (int i = 0; i < 4; i++) fb[i] = 1'b1;
        run_frame(1'b0, 4, 1'b1, -1, 1'b0);
        if (cap_y.size() >= 31) begin
            chk("t6_wide", cap_y[30], 68);
`ifdef GFSK_MOD_SAT_EN
            chk("t6_narrow_sat", cap_y6[30], 31);
`else
            chk("t6_narrow_wrap", cap_y6[30], 4);
`endif
        end
`ifdef GFSK_MOD_SAT_EN
        chk("t6_sat_flag6", int'(sat_flag6), 1);
        chk("t6_sat_flag", int'(sat_flag), 0);
`endif

        // Reset mid-DATA, then coefficients must read back as zero.
        run_frame(1'b0, 4, 1'b1, 14, 1'b0);
        for (int i = 0; i < 9; i++) ctap[i] = 0;
        fb[0] = 1;
        run_frame(1'b0, 1, 1'b1, -1, 1'b0);
        chk("t7_len", int'(cap_y.size()), 32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
